// File: rtl/pcs_scrambler_mc.sv
// pcs_scrambler_mc: multi-lane 64b/66b self-synchronous scrambler/descrambler.
// Adds a skid buffer and per-lane header-error counters; PCS_SCR_BYPASS_EN adds scr_bypass.
module pcs_scrambler_mc #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned MODE      = 0,
    parameter logic [57:0] SEED      = 58'h3FF_FFFF_FFFF_FFFF,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                           pcs_clk,
    input  logic                           pcs_rst_n,
    input  logic [NUM_LANES*66-1:0]        in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_LANES*66-1:0]        out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic                           err_clr,
`ifdef PCS_SCR_BYPASS_EN
    input  logic                           scr_bypass,
`endif
    output logic [NUM_LANES-1:0]           hdr_err_flag,
    output logic [NUM_LANES*CNT_WIDTH-1:0] hdr_err_cnt
);

    logic [NUM_LANES-1:0][57:0]          lfsr;
    logic [NUM_LANES-1:0][57:0]          lfsr_nxt;
    logic [NUM_LANES-1:0][CNT_WIDTH-1:0] cnt;
    logic [NUM_LANES*66-1:0]             proc;
    logic [NUM_LANES*66-1:0]             skid_data;
    logic                                skid_full;
    logic                                skid_full_nxt;
    logic                                accept;
    logic                                bypass;
    logic                                out_free;
    logic [NUM_LANES-1:0]                hdr_bad;
    logic [NUM_LANES-1:0]                hdr_hit;

    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    assign hdr_hit  = hdr_bad & {NUM_LANES{accept}};

`ifdef PCS_SCR_BYPASS_EN
    assign bypass = scr_bypass;
`else
    assign bypass = 1'b0;
`endif

    // 64 serial LFSR steps unrolled; bit 2 of each lane is processed first.
    always_comb begin
        logic [57:0] s;
        logic        b;
        logic        o;
        s        = '0;
        b        = 1'b0;
        o        = 1'b0;
        proc     = in_data;
        lfsr_nxt = lfsr;
        hdr_bad  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            s = lfsr[l];
            for (int i = 0; i < 64; i++) begin
                b = in_data[l*66 + 2 + i];
                o = b ^ s[38] ^ s[57];
                s = {s[56:0], (MODE == 0) ? o : b};
                proc[l*66 + 2 + i] = bypass ? b : o;
            end
            if (!bypass) begin
                lfsr_nxt[l] = s;
            end
            hdr_bad[l] = (in_data[l*66 + 1] == in_data[l*66]);
        end
    end

    // in_ready never covers a full skid, so accept and a full skid never coincide.
    always_comb begin
        skid_full_nxt = skid_full;
        if (out_free) begin
            skid_full_nxt = 1'b0;
        end else if (accept) begin
            skid_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge pcs_clk) begin
        if (!pcs_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
            in_ready  <= 1'b0;
            lfsr      <= {NUM_LANES{SEED}};
        end else begin
            if (accept) begin
                lfsr <= lfsr_nxt;
            end
            if (out_free) begin
                if (skid_full) begin
                    out_data  <= skid_data;
                    out_valid <= 1'b1;
                end else if (accept) begin
                    out_data  <= proc;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_data <= proc;
            end
            skid_full <= skid_full_nxt;
            in_ready  <= !skid_full_nxt;
        end
    end

    always_ff @(posedge pcs_clk) begin
        if (!pcs_rst_n) begin
            cnt          <= '0;
            hdr_err_flag <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (err_clr) begin
                    cnt[l]          <= hdr_hit[l] ? CNT_WIDTH'(1) : '0;
                    hdr_err_flag[l] <= hdr_hit[l];
                end else if (hdr_hit[l]) begin
                    hdr_err_flag[l] <= 1'b1;
                    if (cnt[l] != '1) begin
                        cnt[l] <= cnt[l] + 1'b1;
                    end
                end
            end
        end
    end

    assign hdr_err_cnt = cnt;

endmodule
